// File: rtl/spi_master_pkg.sv
// Shared types and constants for the SPI master datapath blocks.
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANSMIT  = 2'd1,
    WAIT_FIFO = 2'd2
  } tx_state_t;

  localparam int SPI_WORD_BITS       = 32;
  localparam int SPI_QUAD_WORD_EDGES = 8;
  localparam int SPI_CNT_W           = 16;
  localparam logic [SPI_CNT_W-1:0] SPI_CNT_RST = 16'd8;

  // Reverse byte order so that byte 0 of the FIFO word leaves the shifter first.
  function automatic logic [SPI_WORD_BITS-1:0] byte_swap(input logic [SPI_WORD_BITS-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_master_tx.sv
// SPI master transmit datapath: serializes TX FIFO words onto one (standard) or four (quad) lanes.
module spi_master_tx
  import spi_master_pkg::*;
#(
  parameter int ENDIAN = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 tx_edge,
  output logic                 tx_done,
  output logic                 sdo0,
  output logic                 sdo1,
  output logic                 sdo2,
  output logic                 sdo3,
  input  logic                 en_quad_in,
  input  logic [SPI_CNT_W-1:0] counter_in,
  input  logic                 counter_in_upd,
  input  logic [31:0]          data,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 clk_en_o
);

  tx_state_t            state;
  logic [SPI_CNT_W-1:0] counter;
  logic [SPI_CNT_W-1:0] counter_trgt;
  logic [31:0]          sreg;

  logic        reg_done;
  logic        accept;
  logic [31:0] load_word;
  logic [31:0] shifted;

  assign reg_done = (!en_quad_in && counter[4:0] == 5'(SPI_WORD_BITS - 1)) ||
                    ( en_quad_in && counter[2:0] == 3'(SPI_QUAD_WORD_EDGES - 1));
  assign tx_done  = (state == TRANSMIT) && tx_edge && (counter == counter_trgt - 1'b1);

  assign load_word = (ENDIAN != 0) ? data : byte_swap(data);
  assign shifted   = en_quad_in ? {sreg[27:0], 4'b0000} : {sreg[30:0], 1'b0};
  assign accept    = data_valid && data_ready;

  assign sdo0 = en_quad_in ? sreg[28] : sreg[31];
  assign sdo1 = en_quad_in & sreg[29];
  assign sdo2 = en_quad_in & sreg[30];
  assign sdo3 = en_quad_in & sreg[31];

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    data_ready = 1'b0;
    clk_en_o   = 1'b0;
    case (state)
      // rstn gating keeps data_ready low while reset is held, even with en high.
      IDLE: data_ready = en && rstn;
      TRANSMIT: begin
        clk_en_o = 1'b1;
        if (tx_edge && !tx_done && reg_done) begin
          data_ready = 1'b1;
          // Stop the SPI clock in the same cycle the FIFO is found empty.
          if (!data_valid) clk_en_o = 1'b0;
        end
      end
      WAIT_FIFO: data_ready = 1'b1;
      default: begin
        data_ready = 1'b0;
        clk_en_o   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so later writes in the block override earlier ones cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      counter      <= '0;
      counter_trgt <= SPI_CNT_RST;
      sreg         <= '0;
    end else begin
      if (counter_in_upd)
        counter_trgt <= en_quad_in ? {2'b00, counter_in[15:2]} : counter_in;

      case (state)
        IDLE: begin
          if (accept) begin
            sreg    <= load_word;
            counter <= '0;
            state   <= TRANSMIT;
          end
        end
        TRANSMIT: begin
          if (tx_edge) begin
            counter <= counter + 1'b1;
            sreg    <= shifted;
            if (tx_done) begin
              counter <= '0;
              state   <= IDLE;
            end else if (reg_done) begin
              if (data_valid) sreg  <= load_word;
              else            state <= WAIT_FIFO;
            end
          end
        end
        WAIT_FIFO: begin
          // counter is kept so the bit count continues across the stall.
          if (data_valid) begin
            sreg  <= load_word;
            state <= TRANSMIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI master transmit datapath; serializes 32-bit words from the TX FIFO onto sdo0 (standard) or sdo0..sdo3 (quad), MSB-first per transmitted byte.
- Sits beside the SPI receive path, under the SPI controller FSM.
- The SPI clock generator supplies one-cycle tx_edge strobes. This block gates that generator through clk_en_o when the FIFO runs dry.

Parameters:
- ENDIAN, 0, word byte order on load: 0 = little endian (data[7:0] sent first), 1 = big endian (data[31:24] sent first).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- en  in  1  start/continue transmit request from controller
- tx_edge  in  1  one-cycle strobe: shift out next bit(s)
- tx_done  out  1  last bit(s) of transfer shifted on this edge
- sdo0  out  1  serial data lane 0 (standard-mode output)
- sdo1  out  1  quad lane 1
- sdo2  out  1  quad lane 2
- sdo3  out  1  quad lane 3
- en_quad_in  in  1  1 = quad mode (4 bits per edge)
- counter_in  in  16  transfer length in bits
- counter_in_upd  in  1  load counter_in into target register
- data  in  32  word from TX FIFO
- data_valid  in  1  FIFO word available
- data_ready  out  1  block accepts word this cycle
- clk_en_o  out  1  enable SPI clock generator

Behaviour:
- Reset (rstn low, async): state IDLE, counter=0, counter_trgt=8, shift register=0. Outputs: sdo0..3=0, tx_done=0, data_ready=0, clk_en_o=0.
- Target update: when counter_in_upd=1, counter_trgt <= en_quad_in ? {2'b00,counter_in[15:2]} : counter_in. Takes effect next cycle, in any state. The controller updates the target only in IDLE.
- Constraints: counter_in >= 1 in standard mode, >= 4 in quad mode, and a multiple of 4 in quad mode. Violations are unchecked.
- Load conversion, applied on every accepted word:
  - ENDIAN=0: shift register <= {data[7:0],data[15:8],data[23:16],data[31:24]}.
  - ENDIAN=1: shift register <= data.
- Lane mapping:
  - Standard mode: sdo0=sreg[31]; sdo1..3=0.
  - Quad mode: {sdo3,sdo2,sdo1,sdo0}=sreg[31:28].
  - Lanes are driven combinationally from the registered sreg, so they change the cycle after a load or shift.
- reg_done = (!en_quad_in && counter[4:0]==31) || (en_quad_in && counter[2:0]==7).
- tx_done = (state==TRANSMIT) && tx_edge && (counter==counter_trgt-1).
- IDLE:
  - clk_en_o=0; data_ready=en.
  - If en && data_valid: load sreg, counter=0, go to TRANSMIT.
- TRANSMIT:
  - clk_en_o=1; data_ready=0 unless stated below.
  - On tx_edge: counter+1; sreg shifts left by 1 (standard) or 4 (quad), zero fill.
  - On tx_done (takes priority over reg_done): counter=0, go to IDLE. Unsent bits of a partial final word are discarded.
  - Else on reg_done: data_ready=1.
    - If data_valid: load the new word; the shift is overridden by the load; stay in TRANSMIT with no gap edge.
    - Else: clk_en_o=0 in the same cycle, go to WAIT_FIFO.
  - No tx_edge: hold.
- WAIT_FIFO:
  - clk_en_o=0; data_ready=1.
  - On data_valid: load, go to TRANSMIT. counter is kept, continuing the bit count.
- en deasserted mid-transfer is ignored. Only tx_done returns the block to IDLE.
- tx_edge outside TRANSMIT is ignored.
- Handshake: a word transfers only in a cycle where both data_valid and data_ready are 1. data_ready never depends combinationally on data_valid.

Decomposition:
- Shared package spi_master_pkg holds:
  - tx_state_t enum {IDLE, TRANSMIT, WAIT_FIFO}, logic [1:0].
  - Constants: SPI_WORD_BITS=32, SPI_QUAD_WORD_EDGES=8, SPI_CNT_W=16, SPI_CNT_RST=8.
- No sub-module. A single FSM, counter and shift register is the natural size.

Test Plan:
- Standard, ENDIAN=0, counter_in=32, word 0x11223344 → sdo0 sequence 0x44,0x33,0x22,0x11 MSB-first over 32 edges; tx_done on edge 32; state returns to IDLE.
- Quad, ENDIAN=1, counter_in=64, words 0xA5A5F00F, 0x12345678, both available → nibbles A,5,A,5,F,0,0,F,1,2,...,8 on 16 edges; second load at edge 8 with no stall; tx_done on edge 16.
- Standard, counter_in=64, second word withheld 10 cycles → data_ready=1 and clk_en_o=0 from edge 32 until data_valid; counter=32 preserved; transmission resumes correctly.
- Standard, counter_in=12, word 0xABCD1234, ENDIAN=1 → bits 1010_1011_1100; tx_done on edge 12; rest of word dropped; data_ready not asserted mid-word.
- rstn asserted mid-transfer at edge 5 → sdo0..3=0, clk_en_o=0, data_ready=0 and counter_trgt=8 immediately; after release, an 8-bit transfer completes with tx_done on edge 8.
- counter_in_upd with counter_in=20 and en_quad_in=1 in IDLE → target 5; quad transfer ends with tx_done on edge 5.
